parking_gate_ctrl: RTL

//  Parametrised entrance-gate controller for a multi-slot car park. Runs the entry password FSM and blocks entry when full.

---
 rtl/parking_gate_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
// Entrance-gate controller for a multi-slot car park. Runs the password
// entry FSM, counts wrong attempts with a timed lockout, tracks lot
// occupancy and drives the lamps, barrier strobe and two 7-seg digits.
//
// Ports
//   clk              clock
//   reset_n          asynchronous, active-low reset
//   sensor_entrance  car present at entry barrier
//   sensor_exit      car passed through entry barrier
//   car_leave        one-cycle pulse, a car left via the exit lane
//   password         keypad value, sampled only with pw_valid
//   pw_valid         one-cycle strobe, password is presented
//   GREEN_LED        green lamp
//   RED_LED          red lamp
//   gate_open        barrier lift command
//   occupancy        cars currently parked
//   full             occupancy == CAPACITY (combinational)
//   locked           controller is in LOCKOUT
//   HEX_1, HEX_2     active-low 7-seg digits, bit order gfedcba
//
// State     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a car at the entry barrier
// WAIT_PW   | car present, waiting for a password (times out)
// WRONG_PW  | last password was wrong, waiting for another attempt
// RIGHT_PW  | password accepted, barrier open until the car passes
// STOP      | tailgate detected, barrier held until a correct password
// LOCKOUT   | too many wrong attempts, inputs ignored for a fixed time
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int                     PW_WIDTH    = 4,
    parameter logic [PW_WIDTH-1:0]    PASSWORD    = 4'b0110,
    parameter int                     CAPACITY    = 8,
    parameter int                     CNT_W       = 4,
    parameter int                     TIMEOUT     = 16,
    parameter int                     MAX_TRIES   = 3,
    parameter int                     LOCK_CYCLES = 32,
    parameter int                     BLINK_DIV   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sensor_entrance,
    input  logic                sensor_exit,
    input  logic                car_leave,
    input  logic [PW_WIDTH-1:0] password,
    input  logic                pw_valid,
    output logic                GREEN_LED,
    output logic                RED_LED,
    output logic                gate_open,
    output logic [CNT_W-1:0]    occupancy,
    output logic                full,
    output logic                locked,
    output logic [6:0]          HEX_1,
    output logic [6:0]          HEX_2
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_PW  = 3'd1;
    localparam logic [2:0] S_WRONG_PW = 3'd2;
    localparam logic [2:0] S_RIGHT_PW = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;

    localparam int WAIT_W  = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(TIMEOUT - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_DIV - 1);
    localparam logic [TRY_W-1:0]   TRY_LAST   = TRY_W'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0]   CAP        = CNT_W'(CAPACITY);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_U   = 7'b1000001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_N   = 7'b0101011;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_P   = 7'b0001100;
    localparam logic [6:0] SEG_L   = 7'b1000111;
    localparam logic [6:0] SEG_O   = 7'b0100011;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink;
    logic [TRY_W-1:0]   tries;

    logic pw_ok;
    logic pw_bad;
    logic tries_hit;
    logic try_inc;
    logic try_clr;
    logic occ_inc;

    assign pw_ok     = pw_valid && (password == PASSWORD);
    assign pw_bad    = pw_valid && (password != PASSWORD);
    // The attempt being counted now is the one that reaches MAX_TRIES.
    assign tries_hit = (tries >= TRY_LAST);
    assign full      = (occupancy == CAP);

    always_comb begin
        state_next = state;
        try_inc    = 1'b0;
        try_clr    = 1'b0;
        occ_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sensor_entrance && !full) state_next = S_WAIT_PW;
            end
            S_WAIT_PW: begin
                if (pw_ok) begin
                    state_next = S_RIGHT_PW;
                end else if (pw_bad) begin
                    try_inc    = 1'b1;
                    state_next = tries_hit ? S_LOCKOUT : S_WRONG_PW;
                end else if (wait_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_WRONG_PW: begin
                if (pw_ok) begin
                    state_next = S_RIGHT_PW;
                end else if (pw_bad) begin
                    try_inc = 1'b1;
                    if (tries_hit) state_next = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_next = S_IDLE;
                    try_clr    = 1'b1;
                end
            end
            S_RIGHT_PW: begin
                if (sensor_entrance && sensor_exit) begin
                    state_next = S_STOP;
                end else if (sensor_exit) begin
                    state_next = S_IDLE;
                    occ_inc    = 1'b1;
                end
            end
            S_STOP: begin
                if (pw_ok) state_next = S_RIGHT_PW;
            end
            default: state_next = S_IDLE;
        endcase
        if ((state_next == S_RIGHT_PW) && (state != S_RIGHT_PW)) try_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            tries <= '0;
        end else begin
            state <= state_next;
            if (try_clr)      tries <= '0;
            else if (try_inc) tries <= tries + 1'b1;
        end
    end

    // Wait and lockout timers load on state entry and count down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            if ((state_next == S_WAIT_PW) && (state != S_WAIT_PW))
                wait_cnt <= WAIT_LOAD;
            else if ((state == S_WAIT_PW) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - 1'b1;

            if ((state_next == S_LOCKOUT) && (state != S_LOCKOUT))
                lock_cnt <= LOCK_LOAD;
            else if ((state == S_LOCKOUT) && (lock_cnt != '0))
                lock_cnt <= lock_cnt - 1'b1;
        end
    end

    // Blink restarts from off on every state change so each blinking
    // state begins with a predictable phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state_next != state) begin
            blink_cnt <= BLINK_LOAD;
            blink     <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= BLINK_LOAD;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    // A car entering and one leaving on the same edge cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            case ({occ_inc, car_leave})
                2'b10:   if (occupancy != CAP) occupancy <= occupancy + 1'b1;
                2'b01:   if (occupancy != '0)  occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            gate_open <= 1'b0;
            locked    <= 1'b0;
            HEX_1     <= SEG_OFF;
            HEX_2     <= SEG_OFF;
        end else begin
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            gate_open <= 1'b0;
            locked    <= 1'b0;
            HEX_1     <= SEG_OFF;
            HEX_2     <= SEG_OFF;
            case (state)
                S_IDLE: begin
                    if (full) begin
                        RED_LED <= 1'b1;
                        HEX_1   <= SEG_F;
                        HEX_2   <= SEG_U;
                    end
                end
                S_WAIT_PW: begin
                    RED_LED <= 1'b1;
                    HEX_1   <= SEG_E;
                    HEX_2   <= SEG_N;
                end
                S_WRONG_PW: begin
                    RED_LED <= blink;
                    HEX_1   <= SEG_E;
                    HEX_2   <= SEG_E;
                end
                S_RIGHT_PW: begin
                    GREEN_LED <= blink;
                    gate_open <= 1'b1;
                    HEX_1     <= SEG_6;
                    HEX_2     <= SEG_0;
                end
                S_STOP: begin
                    RED_LED <= blink;
                    HEX_1   <= SEG_5;
                    HEX_2   <= SEG_P;
                end
                S_LOCKOUT: begin
                    RED_LED <= 1'b1;
                    locked  <= 1'b1;
                    HEX_1   <= SEG_L;
                    HEX_2   <= SEG_O;
                end
                default: begin
                    HEX_1 <= SEG_OFF;
                    HEX_2 <= SEG_OFF;
                end
            endcase
        end
    end

endmodule
